// File: rtl/mem_arbiter.sv
// mem_arbiter: lets the instruction fetch port and the data port share one
// single-port memory. Each access runs the fixed sequence
// IDLE -> ISSUE -> WAIT -> RESP, so one access completes every MEM_LAT+3 cycles.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration.
// Without it, the data port always wins.
module mem_arbiter #(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic             owner_dm;
    logic             any_req;
    logic             grant_dm;

    assign any_req = if_req | dm_req;

`ifdef MEM_ARB_RR_EN
    // last_if = 1 means the fetch port took the most recent grant.
    // Its reset value makes the data port win the first tie.
    logic last_if;

    assign grant_dm = dm_req & (~if_req | last_if);

    // Round-robin pointer: remember which port took each grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_if <= 1'b1;
        end else if (state == IDLE && any_req) begin
            last_if <= ~grant_dm;
        end
    end
`else
    assign grant_dm = dm_req;
`endif

    // Stalls are the only combinational input-to-output paths
    assign if_stall = if_req & ~if_ack;
    assign dm_stall = dm_req & ~dm_ack;
    assign busy     = (state != IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic for the fixed access sequence
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_req) next_state = ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT:    if (cnt == '0) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: latch the winner in IDLE, strobe in ISSUE,
    // count down in WAIT, then capture read data and raise ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            owner_dm  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            mem_en <= 1'b0;
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        mem_en   <= 1'b1;
                        owner_dm <= grant_dm;
                        mem_addr <= grant_dm ? dm_addr : if_addr;
                        mem_we   <= grant_dm & dm_we;
                        if (grant_dm) begin
                            mem_wdata <= dm_wdata;
                        end
                    end
                end
                ISSUE: begin
                    cnt <= CNT_LOAD;
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        if (!mem_we) begin
                            if (owner_dm) begin
                                dm_rdata <= mem_rdata;
                            end else begin
                                if_rdata <= mem_rdata;
                            end
                        end
                        dm_ack <= owner_dm;
                        if_ack <= ~owner_dm;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter with hand-computed cycle
// offsets. The main instance uses MEM_LAT=2 and a behavioural memory.
// Two extra instances (MEM_LAT=1 and MEM_LAT=15) check the latency extremes.
module tb_mem_arbiter;

    localparam int AW  = 30;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    logic          if_req, if_ack, if_stall;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          dm_req, dm_we, dm_ack, dm_stall;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata, dm_rdata;
    logic          mem_en, mem_we, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .if_rdata(if_rdata), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    // Memory model: 64 words, preset during reset.
    // Read data is valid only in the cycle MEM_LAT after the strobe.
    logic [DW-1:0] mem [0:63];
    bit            pend = 1'b0;
    int            lat_left = 0;
    logic [5:0]    pend_addr = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA5A50000 + i;
            mem[16] <= 32'hDEADBEEF;
        end else if (mem_en && mem_we) begin
            mem[mem_addr[5:0]] <= mem_wdata;
        end
    end

    always @(posedge clk) begin
        if (mem_en) begin
            pend      <= 1'b1;
            lat_left  <= LAT - 1;
            pend_addr <= mem_addr[5:0];
        end else if (pend) begin
            if (lat_left == 0) pend <= 1'b0;
            else lat_left <= lat_left - 1;
        end
    end

    assign mem_rdata = (pend && lat_left == 0) ? mem[pend_addr] : 32'hBAD0BAD0;

    // Latency-extreme instances: index 0 is MEM_LAT=1, index 1 is MEM_LAT=15
    logic          lat_req, idle_bit;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata, lat_rdata;
    logic          x_if_ack[2], x_if_stall[2], x_dm_ack[2], x_dm_stall[2];
    logic          x_mem_en[2], x_mem_we[2], x_busy[2];
    logic [DW-1:0] x_if_rdata[2], x_dm_rdata[2], x_mem_wdata[2];
    logic [AW-1:0] x_mem_addr[2];

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(idle_bit), .if_addr(lat_addr), .if_ack(x_if_ack[0]),
        .if_rdata(x_if_rdata[0]), .if_stall(x_if_stall[0]),
        .dm_req(lat_req), .dm_we(idle_bit), .dm_addr(lat_addr), .dm_wdata(lat_wdata),
        .dm_ack(x_dm_ack[0]), .dm_rdata(x_dm_rdata[0]), .dm_stall(x_dm_stall[0]),
        .mem_en(x_mem_en[0]), .mem_we(x_mem_we[0]), .mem_addr(x_mem_addr[0]),
        .mem_wdata(x_mem_wdata[0]), .mem_rdata(lat_rdata), .busy(x_busy[0])
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(15)) u_lat15 (
        .clk(clk), .rst_n(rst_n),
        .if_req(idle_bit), .if_addr(lat_addr), .if_ack(x_if_ack[1]),
        .if_rdata(x_if_rdata[1]), .if_stall(x_if_stall[1]),
        .dm_req(lat_req), .dm_we(idle_bit), .dm_addr(lat_addr), .dm_wdata(lat_wdata),
        .dm_ack(x_dm_ack[1]), .dm_rdata(x_dm_rdata[1]), .dm_stall(x_dm_stall[1]),
        .mem_en(x_mem_en[1]), .mem_we(x_mem_we[1]), .mem_addr(x_mem_addr[1]),
        .mem_wdata(x_mem_wdata[1]), .mem_rdata(lat_rdata), .busy(x_busy[1])
    );

    int            nChecks = 0;
    int            nFails  = 0;
    int            tStart, dAck, iAck, dLeft;
    logic [DW-1:0] dRd, iRd;
    logic [7:0]    order;
    logic          stallAtD;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive both request ports at the next falling edge.
    // Record the cycle in which the arbiter first sees the request.
    task automatic applyStimulus(input logic d, input logic i, input logic we,
                                 input logic [AW-1:0] da, input logic [DW-1:0] wd,
                                 input logic [AW-1:0] ia);
        @(negedge clk);
        dm_req   = d;
        if_req   = i;
        dm_we    = we;
        dm_addr  = da;
        dm_wdata = wd;
        if_addr  = ia;
        tStart   = cyc;
    endtask

    // Run until both requests are served.
    // The data port is kept requesting for dmNeed acks in total.
    task automatic serveAll(input int dmNeed, input int budget);
        dAck = -1; iAck = -1; order = '0; dLeft = dmNeed; stallAtD = 1'b0;
        for (int n = 0; n < budget && (dm_req || if_req); n++) begin
            @(negedge clk);
            if (dm_ack) begin
                if (dAck < 0) dAck = cyc;
                dRd      = dm_rdata;
                stallAtD = if_stall;
                order    = {order[6:0], 1'b1};
                dLeft--;
                if (dLeft <= 0) dm_req = 1'b0;
            end
            if (if_ack) begin
                iAck   = cyc;
                iRd    = if_rdata;
                order  = {order[6:0], 1'b0};
                if_req = 1'b0;
            end
        end
        if (dm_req || if_req) begin
            checkOutput("serve_timeout", 32'(dm_req | if_req), 32'd0);
            dm_req = 1'b0;
            if_req = 1'b0;
        end
    endtask

    initial begin
        int a1, a15, ackCount;
        rst_n     = 1'b0;
        lat_req   = 1'b0;
        idle_bit  = 1'b0;
        lat_addr  = '0;
        lat_wdata = '0;
        lat_rdata = 32'hCAFEF00D;
        dm_req = 1'b0; if_req = 1'b0; dm_we = 1'b0;
        dm_addr = '0; dm_wdata = '0; if_addr = '0;
        repeat (3) @(negedge clk);

        checkOutput("rst_busy",     32'(busy),     32'd0);
        checkOutput("rst_mem_en",   32'(mem_en),   32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_dm_rdata", dm_rdata,      32'd0);
        checkOutput("rst_if_ack",   32'(if_ack),   32'd0);
        rst_n = 1'b1;

        // Tie immediately after reset: the data port wins in either mode
        applyStimulus(1'b1, 1'b1, 1'b0, 30'h10, 32'h0, 30'h11);
        serveAll(1, 30);
        checkOutput("tie_dm_ack_cyc", dAck - tStart, 32'd4);
        checkOutput("tie_if_ack_cyc", iAck - tStart, 32'd9);
        checkOutput("tie_dm_rdata",   dRd,           32'hDEADBEEF);
        checkOutput("tie_if_rdata",   iRd,           32'hA5A50011);
        checkOutput("tie_if_stall",   32'(stallAtD), 32'd1);

        // Repeated tie: the data port requests twice back to back
        applyStimulus(1'b1, 1'b1, 1'b0, 30'h12, 32'h0, 30'h13);
        serveAll(2, 40);
`ifdef MEM_ARB_RR_EN
        checkOutput("rr_order",       32'(order[2:0]), 32'b101);
        checkOutput("rr_if_ack_cyc",  iAck - tStart,   32'd9);
`else
        checkOutput("fix_order",      32'(order[2:0]), 32'b110);
        checkOutput("fix_if_ack_cyc", iAck - tStart,   32'd14);
`endif

        // Single load
        applyStimulus(1'b1, 1'b0, 1'b0, 30'h10, 32'h0, 30'h0);
        @(negedge clk);
        checkOutput("ld_mem_en",   32'(mem_en),   32'd1);
        checkOutput("ld_mem_we",   32'(mem_we),   32'd0);
        checkOutput("ld_mem_addr", 32'(mem_addr), 32'h10);
        checkOutput("ld_stall",    32'(dm_stall), 32'd1);
        serveAll(1, 20);
        checkOutput("ld_ack_cyc",  dAck - tStart, 32'd4);
        checkOutput("ld_rdata",    dRd,           32'hDEADBEEF);
        checkOutput("ld_stall_at_ack", 32'(dm_stall), 32'd0);

        // Store; inputs change mid-access and must be ignored
        applyStimulus(1'b1, 1'b0, 1'b1, 30'h20, 32'h12345678, 30'h0);
        @(negedge clk);
        checkOutput("st_mem_en",    32'(mem_en), 32'd1);
        checkOutput("st_mem_we",    32'(mem_we), 32'd1);
        checkOutput("st_mem_wdata", mem_wdata,   32'h12345678);
        dm_addr  = 30'h3F;
        dm_wdata = 32'hFFFFFFFF;
        serveAll(1, 20);
        checkOutput("st_ack_cyc",   dAck - tStart,   32'd4);
        checkOutput("st_rdata_kept", dm_rdata,       32'hDEADBEEF);
        checkOutput("st_addr_held", 32'(mem_addr),   32'h20);
        checkOutput("st_wdata_held", mem_wdata,      32'h12345678);

        applyStimulus(1'b1, 1'b0, 1'b0, 30'h20, 32'h0, 30'h0);
        serveAll(1, 20);
        checkOutput("st_readback",  dRd, 32'h12345678);

        // Fetch in flight, then data request arrives; the fetch finishes first
        applyStimulus(1'b0, 1'b1, 1'b0, 30'h0, 32'h0, 30'h14);
        repeat (2) @(negedge clk);
        dm_req = 1'b1; dm_addr = 30'h10; dm_we = 1'b0;
        checkOutput("mid_if_stall", 32'(if_stall), 32'd1);
        serveAll(1, 30);
        checkOutput("mid_if_ack_cyc", iAck - tStart, 32'd4);
        checkOutput("mid_dm_ack_cyc", dAck - tStart, 32'd9);
        checkOutput("mid_if_rdata",   iRd,           32'hA5A50014);
        checkOutput("mid_dm_rdata",   dRd,           32'hDEADBEEF);

        // Reset during WAIT
        applyStimulus(1'b1, 1'b0, 1'b0, 30'h11, 32'h0, 30'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("ar_busy",     32'(busy),     32'd0);
        checkOutput("ar_mem_en",   32'(mem_en),   32'd0);
        checkOutput("ar_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("ar_dm_rdata", dm_rdata,      32'd0);
        dm_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ackCount = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (dm_ack || if_ack) ackCount++;
        end
        checkOutput("ar_no_ack",   ackCount, 32'd0);
        checkOutput("ar_rdata_ign", dm_rdata, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 30'h11, 32'h0, 30'h0);
        serveAll(1, 20);
        checkOutput("ar_after_ack_cyc", dAck - tStart, 32'd4);
        checkOutput("ar_after_rdata",   dRd,           32'hA5A50011);

        // Latency extremes, with a one-cycle (withdrawn) request
        @(negedge clk);
        lat_req = 1'b1;
        tStart  = cyc;
        @(negedge clk);
        lat_req = 1'b0;
        a1 = -1; a15 = -1;
        for (int n = 0; n < 25; n++) begin
            if (x_dm_ack[0] && a1 < 0)  a1  = cyc;
            if (x_dm_ack[1] && a15 < 0) a15 = cyc;
            @(negedge clk);
        end
        checkOutput("lat1_ack_cyc",  a1 - tStart,   32'd3);
        checkOutput("lat15_ack_cyc", a15 - tStart,  32'd17);
        checkOutput("lat1_rdata",    x_dm_rdata[0], 32'hCAFEF00D);
        checkOutput("lat15_rdata",   x_dm_rdata[1], 32'hCAFEF00D);
        checkOutput("lat15_idle",    32'(x_busy[1]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFails);
        $finish;
    end

endmodule
